// File: rtl/sweep_pkg.sv
// Shared types and constants for the up/down sweep controller.
package sweep_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_UP = 2'd1,
    RUN_DN = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Sweep mode encodings carried on the command channel
  localparam logic [1:0] MODE_UP  = 2'b00;
  localparam logic [1:0] MODE_DN  = 2'b01;
  localparam logic [1:0] MODE_TRI = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

endpackage

// File: rtl/updn_sweep_ctrl_if.sv
// Sweep command channel: valid/ready handshake plus the command fields.
interface updn_sweep_ctrl_if #(
  parameter int CNT_WIDTH = 4,
  parameter int REP_WIDTH = 4
);

  logic                 valid;
  logic                 ready;
  logic [CNT_WIDTH-1:0] start;
  logic [CNT_WIDTH-1:0] limit;
  logic [1:0]           mode;
  logic [REP_WIDTH-1:0] reps;

  // Command source side
  modport master (
    output valid, start, limit, mode, reps,
    input  ready
  );

  // Controller side
  modport slave (
    input  valid, start, limit, mode, reps,
    output ready
  );

endinterface

// File: rtl/updn_ld_cnt.sv
// Loadable up/down counter; load wins over enable, arithmetic wraps.
module updn_ld_cnt #(
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 en,
  input  logic                 up_dn,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] count_reg;

  // Count register: reset to zero, load a new value, or step by one
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en) begin
      count_reg <= up_dn ? (count_reg + CNT_ONE) : (count_reg - CNT_ONE);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/updn_sweep_ctrl.sv
// Sweep sequencer: accepts commands and steps the counter through up,
// down or repeated triangle sweeps, reporting busy/dir/done.
module updn_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int CNT_WIDTH = 4,
  parameter int REP_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  updn_sweep_ctrl_if.slave     cmd,
  input  logic                 pause,
  input  logic                 abort,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 dir,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 err
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [REP_WIDTH-1:0] REP_ONE = REP_WIDTH'(1);

  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] lo_reg, lo_next;
  logic [CNT_WIDTH-1:0] hi_reg, hi_next;
  logic [1:0]           mode_reg, mode_next;
  logic [REP_WIDTH-1:0] reps_reg, reps_next;
  logic                 dir_reg, dir_next;
  logic                 done_reg, done_next;
  logic                 aborted_reg, aborted_next;
  logic                 err_reg, err_next;

  logic                 cnt_load;
  logic                 cnt_en;
  logic                 cnt_up;
  logic [CNT_WIDTH-1:0] cnt_val;
  logic [CNT_WIDTH-1:0] count_inc;
  logic [CNT_WIDTH-1:0] count_dec;

  updn_ld_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cmd.start),
    .en       (cnt_en),
    .up_dn    (cnt_up),
    .count    (cnt_val)
  );

  // Terminal tests look at the value the counter is about to take
  assign count_inc = cnt_val + CNT_ONE;
  assign count_dec = cnt_val - CNT_ONE;
  assign cnt_up    = (state_reg == RUN_UP);

  // Next-state logic: accept, step, turn around, finish or abort
  always_comb begin
    state_next   = state_reg;
    lo_next      = lo_reg;
    hi_next      = hi_reg;
    mode_next    = mode_reg;
    reps_next    = reps_reg;
    done_next    = 1'b0;
    aborted_next = 1'b0;
    err_next     = 1'b0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd.valid) begin
          cnt_load  = 1'b1;
          lo_next   = cmd.start;
          hi_next   = cmd.limit;
          mode_next = cmd.mode;
          reps_next = cmd.reps;
          // Empty sweeps and the reserved mode finish without stepping
          if ((cmd.mode == MODE_RSV) || (cmd.start == cmd.limit)) begin
            state_next = DONE;
            done_next  = 1'b1;
            err_next   = (cmd.mode == MODE_RSV);
          end else if (cmd.mode == MODE_DN) begin
            state_next = RUN_DN;
          end else begin
            state_next = RUN_UP;
          end
        end
      end
      RUN_UP: begin
        if (abort) begin
          state_next   = DONE;
          done_next    = 1'b1;
          aborted_next = 1'b1;
        end else if (!pause) begin
          cnt_en = 1'b1;
          if (count_inc == hi_reg) begin
            if (mode_reg == MODE_TRI) begin
              state_next = RUN_DN;
            end else begin
              state_next = DONE;
              done_next  = 1'b1;
            end
          end
        end
      end
      RUN_DN: begin
        if (abort) begin
          state_next   = DONE;
          done_next    = 1'b1;
          aborted_next = 1'b1;
        end else if (!pause) begin
          cnt_en = 1'b1;
          if (mode_reg == MODE_TRI) begin
            // Reaching the low turn point closes one triangle; a stored
            // repeat count of zero behaves like one
            if (count_dec == lo_reg) begin
              if (reps_reg <= REP_ONE) begin
                reps_next  = '0;
                state_next = DONE;
                done_next  = 1'b1;
              end else begin
                reps_next  = reps_reg - REP_ONE;
                state_next = RUN_UP;
              end
            end
          end else if (count_dec == hi_reg) begin
            state_next = DONE;
            done_next  = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Direction follows the run state and is held everywhere else
  always_comb begin
    dir_next = dir_reg;
    if (state_next == RUN_UP) begin
      dir_next = 1'b1;
    end else if (state_next == RUN_DN) begin
      dir_next = 1'b0;
    end
  end

  // State and status registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      lo_reg      <= '0;
      hi_reg      <= '0;
      mode_reg    <= MODE_UP;
      reps_reg    <= '0;
      dir_reg     <= 1'b1;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      lo_reg      <= lo_next;
      hi_reg      <= hi_next;
      mode_reg    <= mode_next;
      reps_reg    <= reps_next;
      dir_reg     <= dir_next;
      done_reg    <= done_next;
      aborted_reg <= aborted_next;
      err_reg     <= err_next;
    end
  end

  assign cmd.ready = (state_reg == IDLE);
  assign count     = cnt_val;
  assign dir       = dir_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign aborted   = aborted_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_updn_sweep_ctrl.sv
// Bench for updn_sweep_ctrl: sweep-path reference model compared every
// cycle, plus directed sequences with literal expected count traces.
module tb_updn_sweep_ctrl;

  localparam int CW = 4;
  localparam int RW = 4;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] count;
  logic          dir, busy, done, aborted, err;

  updn_sweep_ctrl_if #(.CNT_WIDTH(CW), .REP_WIDTH(RW)) cmd ();

  updn_sweep_ctrl #(.CNT_WIDTH(CW), .REP_WIDTH(RW)) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (cmd),
    .pause   (pause),
    .abort   (abort),
    .count   (count),
    .dir     (dir),
    .busy    (busy),
    .done    (done),
    .aborted (aborted),
    .err     (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a sweep is the list of values the count must visit
  logic [3:0] m_path[$];
  logic [3:0] m_cnt, m_v, m_nxt;
  logic       m_dir, m_busy, m_done, m_abt, m_err;
  int         m_r;
  bit         started = 1'b0;

  always @(posedge clk) begin
    started = 1'b1;
    if (!rst) begin
      m_path.delete();
      m_cnt = 4'd0; m_dir = 1'b1; m_busy = 1'b0;
      m_done = 1'b0; m_abt = 1'b0; m_err = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0; m_abt = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    end else if (m_busy) begin
      if (abort) begin
        m_path.delete();
        m_done = 1'b1; m_abt = 1'b1;
      end else if (!pause) begin
        m_cnt = m_path.pop_front();
        if (m_path.size() == 0) begin
          m_done = 1'b1;
        end else begin
          m_nxt = m_cnt + 4'd1;
          m_dir = (m_path[0] == m_nxt);
        end
      end
    end else if (cmd.valid) begin
      m_cnt  = cmd.start;
      m_busy = 1'b1;
      m_path.delete();
      m_v = cmd.start;
      if (cmd.mode == 2'b11 || cmd.start == cmd.limit) begin
        m_done = 1'b1;
        m_err  = (cmd.mode == 2'b11);
      end else begin
        if (cmd.mode == 2'b00) begin
          do begin m_v = m_v + 4'd1; m_path.push_back(m_v); end while (m_v != cmd.limit);
        end else if (cmd.mode == 2'b01) begin
          do begin m_v = m_v - 4'd1; m_path.push_back(m_v); end while (m_v != cmd.limit);
        end else begin
          m_r = (cmd.reps == 4'd0) ? 1 : int'(cmd.reps);
          for (int k = 0; k < m_r; k++) begin
            do begin m_v = m_v + 4'd1; m_path.push_back(m_v); end while (m_v != cmd.limit);
            do begin m_v = m_v - 4'd1; m_path.push_back(m_v); end while (m_v != cmd.start);
          end
        end
        m_nxt = cmd.start + 4'd1;
        m_dir = (m_path[0] == m_nxt);
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      check("count",     32'(count),     32'(m_cnt));
      check("dir",       32'(dir),       32'(m_dir));
      check("busy",      32'(busy),      32'(m_busy));
      check("cmd_ready", 32'(cmd.ready), 32'(!m_busy));
      check("done",      32'(done),      32'(m_done));
      check("aborted",   32'(aborted),   32'(m_abt));
      check("err",       32'(err),       32'(m_err));
    end
  end

  int trace[$];
  int exp_q[$];

  // Present a command at a falling edge and hold it until accepted
  task automatic issue(input logic [1:0] mode, input logic [3:0] s,
                       input logic [3:0] l, input logic [3:0] r);
    logic was_ready;
    int   n;
    cmd.valid = 1'b1; cmd.mode = mode; cmd.start = s; cmd.limit = l; cmd.reps = r;
    n = 0;
    do begin
      was_ready = cmd.ready;
      @(negedge clk);
      n++;
    end while (!was_ready && n < 200);
    cmd.valid = 1'b0;
    if (!was_ready) check("accept_timeout", 32'(was_ready), 32'd1);
    $display("cmd mode=%0d start=%0d limit=%0d reps=%0d accepted at %0t", mode, s, l, r, $time);
  endtask

  // Record count on each falling edge up to and including the done cycle
  task automatic collect();
    int n;
    n = 0;
    trace.delete();
    while (1) begin
      trace.push_back(int'(count));
      if (done === 1'b1) break;
      if (n >= 100) begin
        check("done_timeout", 32'(done), 32'd1);
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic expect_trace(input string name);
    check({name, "_len"}, 32'(trace.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < trace.size(); i++)
      check($sformatf("%s[%0d]", name, i), 32'(trace[i]), 32'(exp_q[i]));
  endtask

  task automatic wait_count(input logic [3:0] v, input string name);
    int n;
    n = 0;
    while (count !== v && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(count), 32'(v));
  endtask

  initial begin
    cmd.valid = 1'b0; cmd.mode = 2'b00; cmd.start = 4'd0; cmd.limit = 4'd0; cmd.reps = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_dir",   32'(dir),   32'd1);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_ready", 32'(cmd.ready), 32'd1);
    check("rst_done",  32'(done),  32'd0);
    rst = 1'b1;

    // abort while idle does nothing
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);

    // UP 3 -> 6
    issue(2'b00, 4'd3, 4'd6, 4'd0);
    collect();
    exp_q = '{3, 4, 5, 6};
    expect_trace("up_3_6");
    check("up_err", 32'(err), 32'd0);
    @(negedge clk);
    check("up_busy_drop", 32'(busy), 32'd0);

    // DOWN 1 -> 14 wrapping through zero
    issue(2'b01, 4'd1, 4'd14, 4'd0);
    collect();
    exp_q = '{1, 0, 15, 14};
    expect_trace("dn_1_14");
    @(negedge clk);
    check("dn_dir_hold", 32'(dir), 32'd0);

    // TRI 2..5 twice
    issue(2'b10, 4'd2, 4'd5, 4'd2);
    collect();
    exp_q = '{2, 3, 4, 5, 4, 3, 2, 3, 4, 5, 4, 3, 2};
    expect_trace("tri_2_5_x2");
    @(negedge clk);

    // TRI with start > limit, repeat count zero
    issue(2'b10, 4'd14, 4'd1, 4'd0);
    collect();
    exp_q = '{14, 15, 0, 1, 0, 15, 14};
    expect_trace("tri_wrap_r0");
    @(negedge clk);

    // reserved mode finishes at once with err
    issue(2'b11, 4'd5, 4'd8, 4'd1);
    collect();
    exp_q = '{5};
    expect_trace("rsv");
    check("rsv_err", 32'(err), 32'd1);
    @(negedge clk);

    // start == limit finishes at once without err
    issue(2'b00, 4'd7, 4'd7, 4'd0);
    collect();
    exp_q = '{7};
    expect_trace("eq");
    check("eq_err", 32'(err), 32'd0);
    @(negedge clk);

    // pause at 4 for three cycles, abort at 6
    issue(2'b00, 4'd0, 4'd9, 4'd0);
    wait_count(4'd4, "pa_reach4");
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("pa_hold%0d", i), 32'(count), 32'd4);
    end
    pause = 1'b0;
    wait_count(4'd6, "pa_reach6");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_count",   32'(count),   32'd6);
    check("ab_done",    32'(done),    32'd1);
    check("ab_aborted", 32'(aborted), 32'd1);
    @(negedge clk);

    // second command held valid while the first is still running
    issue(2'b00, 4'd0, 4'd2, 4'd0);
    issue(2'b01, 4'd3, 4'd1, 4'd0);
    collect();
    exp_q = '{3, 2, 1};
    expect_trace("held_dn");
    @(negedge clk);

    // reset in the middle of a triangle sweep
    issue(2'b10, 4'd2, 4'd9, 4'd3);
    wait_count(4'd7, "mid_reach7");
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_busy",  32'(busy),  32'd0);
    check("mid_rst_ready", 32'(cmd.ready), 32'd1);
    check("mid_rst_done",  32'(done),  32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/updn_sweep_ctrl.md
# updn_sweep_ctrl

Sequencer for the team's parameterised up/down counter. Accepts sweep commands (start value, limit, mode, repeat count) over a valid/ready handshake and steps the counter through single up sweeps, single down sweeps or repeated triangle sweeps. It reports progress with busy, direction and a one-cycle done pulse. It sits between a command source (CPU register block or test sequencer) and any logic consuming the count.

## Interface
- CNT_WIDTH, 4, width of counter and of start/limit fields
- REP_WIDTH, 4, width of triangle repeat count
- clk  input  1  sole clock, all state changes on posedge
- rst  input  1  one clock; reset is synchronous and active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command (high only in IDLE)
- cmd_start  input  CNT_WIDTH  first count value; low turn point in triangle mode
- cmd_limit  input  CNT_WIDTH  terminal value; high turn point in triangle mode
- cmd_mode  input  2  00 UP, 01 DOWN, 10 TRI, 11 reserved
- cmd_reps  input  REP_WIDTH  triangle repetitions; 0 treated as 1
- pause  input  1  hold count and state while high
- abort  input  1  terminate running sweep
- count  output  CNT_WIDTH  current counter value
- dir  output  1  1 = counting up, 0 = down (held outside RUN)
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse on sweep end
- aborted  output  1  qualifies done: sweep ended by abort
- err  output  1  qualifies done: reserved mode

## Operation
- States: IDLE, RUN_UP, RUN_DN, DONE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, the following are captured: count<=cmd_start, lo<=cmd_start, hi<=cmd_limit, mode, reps.
  - UP goes to RUN_UP. DOWN goes to RUN_DN. TRI goes to RUN_UP.
  - If start==limit, or mode is 11, go directly to DONE. err=1 in DONE for mode 11.
- RUN_UP: count<=count+1.
  - If count+1==hi: UP goes to DONE; TRI goes to RUN_DN.
- RUN_DN: count<=count-1.
  - DOWN: if count-1==hi, go to DONE (hi holds the limit).
  - TRI: if count-1==lo, decrement the rep counter. If the counter was ≤1, go to DONE; otherwise go to RUN_UP.
- Arithmetic is modulo 2^CNT_WIDTH.
  - UP with start>limit wraps through max→0 and ends at limit.
  - DOWN with start<limit wraps through 0→max.
  - TRI with start>limit wraps the same way in both legs. This is legal, not an error.
- pause=1 in RUN: count, state and rep counter hold. pause is ignored in IDLE and DONE.
- abort=1 in RUN has priority over pause and over a terminal step. The next state is DONE, count holds its value, and aborted=1 with done. abort in IDLE or DONE is ignored.
- DONE: lasts exactly one cycle, done=1, then IDLE. count holds its final value through IDLE until the next accept.
- dir=1 in RUN_UP and 0 in RUN_DN. Elsewhere dir keeps its last value.

## Timing
- Reset (rst=0 at a posedge): state=IDLE, count=0, dir=1, done=aborted=err=0, busy=0, cmd_ready=1. Reset overrides all inputs, including mid-sweep.
- Accept at edge N: count=start after N. First step at edge N+1.
- UP start=s, limit=l (no wrap): count reaches l after edge N+(l−s). done is high in the following cycle, and busy drops one edge after that.
- A command presented while busy is not accepted (cmd_ready=0). cmd_valid may stay high and is taken on the first IDLE cycle.
- done, aborted and err are registered: they assert together for the single DONE cycle.

## Structure
- Package sweep_pkg: state enum (IDLE, RUN_UP, RUN_DN, DONE) and mode constants MODE_UP=2'b00, MODE_DN=2'b01, MODE_TRI=2'b10.
- Sub-module updn_ld_cnt #(CNT_WIDTH): the counter with synchronous active-low reset, load/load_val, en and up_dn.
  - The controller drives load on accept and en=RUN&&!pause&&!abort.
  - The controller also holds hi, lo and the rep counter, and implements the FSM.

## Test plan
- Reset mid-TRI sweep (count=7) → next edge count=0, busy=0, cmd_ready=1, no done.
- UP start=3 limit=6, W=4 → count 3,4,5,6 on consecutive edges, then done=1 for one cycle, busy falls next edge.
- DOWN start=1 limit=14 → count 1,0,15,14, then done (wrap).
- TRI start=2 limit=5 reps=2 → 2,3,4,5,4,3,2,3,4,5,4,3,2, then done.
- UP start=0 limit=9, pause high for 3 cycles at count=4, then abort at count=6 → count holds 4 for 3 cycles; count stays 6; done=aborted=1.
- Mode 11, and separately start==limit → done the cycle after accept with no count change. err=1 only for mode 11.
